instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  IF stage of the MIPS/DLX pipeline: owns the PC, fetches from instruction memory via req/ack,
//  and drives the IF/ID register feeding instruction_decode (instruc, pc_plus4, if_valid).
//  Honours hazard-unit stall and branch/jump redirect from later stages. Bubbles are NOP.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded at reset
//  NOP_WORD   32'h0000_0000  instruction word driven on flush/bubble (sll r0,r0,0)
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  stall        in   1   ID cannot accept: IF/ID and PC hold
//  redirect     in   1   taken branch/jump: flush IF/ID, load PC
//  redirect_pc  in   32  new PC; bits [1:0] ignored (treated as 00)
//  imem_req     out  1   fetch request, address valid while high
//  imem_addr    out  32  word-aligned fetch address (= pc)
//  imem_ack     in   1   imem_rdata valid this cycle for current imem_addr
//  imem_rdata   in   32  fetched instruction word
//  instruc      out  32  IF/ID instruction to instruction_decode
//  pc_plus4     out  32  IF/ID PC+4 of that instruction (branch/link base)
//  if_valid     out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, state=BOOT, imem_req=0, instruc=NOP_WORD,
//   pc_plus4=0, if_valid=0, skid buffer empty. Reset mid-fetch abandons request; no output glitch.
//  FSM states: BOOT, FETCH, HOLD.
//   BOOT : imem_req=0; next cycle -> FETCH.
//   FETCH: imem_req=1, imem_addr=pc.
//    ack & !stall -> IF/ID <= {rdata, pc+4, 1}; pc <= pc+4; stay FETCH (1 instr/cycle max).
//    ack & stall  -> rdata,pc+4 into skid buffer; IF/ID unchanged; -> HOLD.
//    !ack & !stall-> IF/ID <= {NOP_WORD, pc_plus4 unchanged, 0}; pc unchanged.
//    !ack & stall -> IF/ID unchanged.
//   HOLD : imem_req=0; IF/ID unchanged while stall.
//    !stall -> IF/ID <= skid {word, pc+4, 1}; pc <= pc+4; -> FETCH.
//  Redirect (highest priority, any state, overrides stall): pc <= {redirect_pc[31:2],2'b00};
//   IF/ID <= {NOP_WORD, 0, 0}; skid cleared; ack in same cycle discarded; -> FETCH.
//  Memory contract: req may drop or address change without ack (request abandoned); ack only
//   meaningful while req=1. Latency: ack in cycle N -> instruc/if_valid visible cycle N+1.
//  Arithmetic: pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); pc[1:0] always 00.
//  Stall with if_valid=0 still holds bubble (no spontaneous fill of IF/ID while stalled).
// STRUCTURE
//  Shared pkg (pipeline_pkg): NOP_WORD, RESET_PC defaults, IF FSM state encoding
//   (BOOT/FETCH/HOLD), IF/ID field widths. Shared with instruction_decode and hazard unit.
//  Sub-module if_id_reg: 65-bit pipeline register with load/hold/flush, reset to bubble;
//   FSM, PC and skid buffer stay in instruction_fetch.
// TESTING
//  1 Reset, imem acks every cycle with rdata=addr^32'hA5A5_0000 -> instruc seq 0xA5A5_0000,
//    0xA5A5_0004,... pc_plus4 0x4,0x8,...; if_valid=1 from 2nd cycle after FETCH entry.
//  2 Ack at pc=0x10 with stall=1 for 3 cycles -> IF/ID holds prior instr, imem_req=0 in HOLD;
//    stall drop -> instruc=word@0x10, pc_plus4=0x14 next cycle, no fetch skipped/duplicated.
//  3 redirect=1, redirect_pc=0x0000_0103 with stall=1 and ack=1 same cycle -> next cycle
//    if_valid=0, instruc=NOP_WORD, imem_addr=0x100; acked word dropped.
//  4 Ack delayed 2 cycles per fetch -> if_valid pattern 1,0,0,1; imem_addr stable until ack.
//  5 redirect_pc=0xFFFF_FFFC, then ack -> pc_plus4=0x0000_0000, next imem_addr=0x0.
//  6 rst_n asserted mid-HOLD -> all outputs at reset values immediately (async), BOOT on release.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: IF/ID bundle, IF FSM encoding, reset defaults.
// Imported by instruction_fetch, instruction_decode and the hazard unit.
package pipeline_pkg;
   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] IF_NOP_WORD = 32'h0000_0000;
   localparam int          INSTR_W     = 32;
   localparam int          PC_W        = 32;
   localparam int          IF_ID_W     = INSTR_W + PC_W + 1;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instruc;
      logic [PC_W-1:0]    pc_plus4;
      logic               valid;
   } if_id_t;
endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: load, hold or flush to a bubble.
// Flush wins over load; reset leaves a bubble.
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               flush,
   input  logic [IF_ID_W-1:0] d,
   output logic [IF_ID_W-1:0] q
);
   logic [IF_ID_W-1:0] bubble;
   logic [IF_ID_W-1:0] q_d;
   logic [IF_ID_W-1:0] q_q;

   assign bubble = {NOP_WORD, 32'd0, 1'b0};

   always_comb begin
      q_d = q_q;
      if (flush) begin
         q_d = bubble;
      end else if (load) begin
         q_d = d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= bubble;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;
endmodule

// File: rtl/instruction_fetch.sv
// IF stage: owns the PC, fetches over req/ack and fills IF/ID.
// A word acked during a stall is parked in the skid buffer until ID frees up.
module instruction_fetch
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC,
   parameter logic [31:0] NOP_WORD = IF_NOP_WORD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruc,
   output logic [31:0] pc_plus4,
   output logic        if_valid
);
   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] pc_inc;
   logic        ld, fl;
   if_id_t      ifid_d, ifid_q;
   logic [IF_ID_W-1:0] ifid_vec;

   assign pc_inc = pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      skid_d  = skid_q;
      ld      = 1'b0;
      fl      = 1'b0;
      ifid_d  = ifid_q;
      if (redirect) begin
         // Redirect beats stall and throws away any same-cycle ack
         pc_d    = redirect_pc & ~32'd3;
         skid_d  = 32'd0;
         fl      = 1'b1;
         state_d = FETCH;
      end else begin
         unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (imem_ack && !stall) begin
                  ifid_d = '{imem_rdata, pc_inc, 1'b1};
                  ld     = 1'b1;
                  pc_d   = pc_inc;
               end else if (imem_ack) begin
                  skid_d  = imem_rdata;
                  state_d = HOLD;
               end else if (!stall) begin
                  ifid_d = '{NOP_WORD, ifid_q.pc_plus4, 1'b0};
                  ld     = 1'b1;
               end
            end
            HOLD: begin
               if (!stall) begin
                  ifid_d  = '{skid_q, pc_inc, 1'b1};
                  ld      = 1'b1;
                  pc_d    = pc_inc;
                  state_d = FETCH;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         skid_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         skid_q  <= skid_d;
      end
   end

   if_id_reg #(.NOP_WORD(NOP_WORD)) u_if_id (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ld),
      .flush (fl),
      .d     (ifid_d),
      .q     (ifid_vec)
   );

   assign ifid_q    = if_id_t'(ifid_vec);
   assign imem_req  = (state_q == FETCH);
   assign imem_addr = pc_q;
   assign instruc   = ifid_q.instruc;
   assign pc_plus4  = ifid_q.pc_plus4;
   assign if_valid  = ifid_q.valid;
endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch against a cycle-level reference model.
// Memory returns addr ^ 0xA5A5_0000 so every fetched word identifies its address.
module tb_instruction_fetch;
   localparam logic [31:0] K   = 32'hA5A5_0000;
   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruc;
   logic [31:0] pc_plus4;
   logic        if_valid;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model: mode 0=boot 1=fetching 2=holding a parked word
   int          m_mode;
   logic [31:0] m_pc, m_park, m_ins, m_p4;
   logic        m_v;

   always #5 clk = ~clk;

   assign imem_rdata = imem_addr ^ K;

   instruction_fetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instruc     (instruc),
      .pc_plus4    (pc_plus4),
      .if_valid    (if_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_mode = 0;
      m_pc   = 32'h0;
      m_park = 32'h0;
      m_ins  = NOP;
      m_p4   = 32'h0;
      m_v    = 1'b0;
   endtask

   task automatic check_all();
      chk("instruc", instruc, m_ins);
      chk("pc_plus4", pc_plus4, m_p4);
      chk("if_valid", {31'd0, if_valid}, {31'd0, m_v});
      chk("imem_req", {31'd0, imem_req}, {31'd0, m_mode == 1});
      chk("imem_addr", imem_addr, m_pc);
   endtask

   // one clock: drive at negedge, model steps at posedge, check next negedge
   task automatic cycle(input logic st, input logic rd,
                        input logic [31:0] rpc, input logic ack);
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      imem_ack    = ack;
      @(posedge clk);
      if (rd) begin
         m_pc   = rpc & ~32'd3;
         m_park = 32'h0;
         m_ins  = NOP;
         m_p4   = 32'h0;
         m_v    = 1'b0;
         m_mode = 1;
      end else if (m_mode == 0) begin
         m_mode = 1;
      end else if (m_mode == 1) begin
         if (ack && !st) begin
            m_ins = m_pc ^ K;
            m_p4  = m_pc + 32'd4;
            m_v   = 1'b1;
            m_pc  = m_pc + 32'd4;
         end else if (ack) begin
            m_park = m_pc ^ K;
            m_mode = 2;
         end else if (!st) begin
            m_ins = NOP;
            m_v   = 1'b0;
         end
      end else if (!st) begin
         m_ins  = m_park;
         m_p4   = m_pc + 32'd4;
         m_v    = 1'b1;
         m_pc   = m_pc + 32'd4;
         m_mode = 1;
      end
      @(negedge clk);
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      imem_ack = 1'b0;
      m_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      // streaming, ack every cycle
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("stream_pc4", pc_plus4, 32'h0000_0014);

      // park a word during a stall, then release
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);

      // redirect beats stall and same-cycle ack
      cycle(1'b1, 1'b1, 32'h0000_0103, 1'b1);
      chk("redir_addr", imem_addr, 32'h0000_0100);
      chk("redir_valid", {31'd0, if_valid}, 32'd0);

      // delayed acks
      for (int j = 0; j < 3; j++) begin
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         cycle(1'b0, 1'b0, 32'h0, 1'b0);
         cycle(1'b0, 1'b0, 32'h0, 1'b1);
      end

      // PC wrap
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      chk("wrap_pc4", pc_plus4, 32'h0000_0000);
      chk("wrap_addr", imem_addr, 32'h0000_0000);

      // async reset in the middle of HOLD
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      m_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      check_all();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [31:0] rpc;
         rpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 | $urandom_range(0, 7)
                                          : $urandom;
         cycle($urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 6,
               rpc,
               $urandom_range(0, 99) < 60);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
